// File: rtl/gfx_pkg.sv
// gfx_pkg: shared widths, write record type and grant encodings for the gfx write arbiter
package gfx_pkg;
  localparam int GFX_ADDR_BITS = 12;
  localparam int GFX_DATA_BITS = 16;
  typedef struct packed {
    logic [GFX_ADDR_BITS-1:0] addr;
    logic [GFX_DATA_BITS-1:0] data;
  } gfx_wr_t;
  typedef enum logic [2:0] {GNT_IDLE, GNT_COP, GNT_HOLD, GNT_CPU, GNT_FORCE} gnt_e;
endpackage

// File: rtl/gfx_wr_fifo.sv
// gfx_wr_fifo: synchronous fall-through FIFO of register writes
module gfx_wr_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  gfx_wr_t wdata,
  output gfx_wr_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  gfx_wr_t mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head = mem[rd_ptr[AW-1:0]];
  // a pop does not free a slot for a same-cycle push
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/gfx_wr_arbiter.sv
// gfx_wr_arbiter: shares the gfx register write bus between copper (priority) and queued CPU writes
module gfx_wr_arbiter
  import gfx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STARVE = 8,
  parameter int ADDR_BITS  = GFX_ADDR_BITS,
  parameter int DATA_BITS  = GFX_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] cpu_address,
  input  logic [DATA_BITS-1:0] cpu_data,
  input  logic                 cpu_wr,
  input  logic [ADDR_BITS-1:0] cop_address,
  input  logic [DATA_BITS-1:0] cop_data,
  input  logic                 cop_wr,
  input  logic                 clr_flags,
  output logic [ADDR_BITS-1:0] gfx_address,
  output logic [DATA_BITS-1:0] gfx_data,
  output logic                 gfx_wr,
  output logic                 fifo_full,
  output logic                 cpu_ovf,
  output logic                 cop_ovr
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  logic [SW-1:0] starve_cnt, starve_nxt;
  gfx_wr_t cpu_in, cop_in, head, hold, issue;
  logic hold_v, hold_v_nxt, hold_load, fifo_empty, pop, cop_drop;
  gnt_e gnt;
  assign cpu_in = '{addr: cpu_address, data: cpu_data};
  assign cop_in = '{addr: cop_address, data: cop_data};
  gfx_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(cpu_wr), .pop(pop), .wdata(cpu_in),
    .head(head), .full(fifo_full), .empty(fifo_empty)
  );
  always_comb begin
    gnt = (!fifo_empty && starve_cnt == SW'(MAX_STARVE)) ? GNT_FORCE :
          hold_v ? GNT_HOLD : cop_wr ? GNT_COP : !fifo_empty ? GNT_CPU : GNT_IDLE;
    issue = gnt == GNT_HOLD ? hold : gnt == GNT_COP ? cop_in : head;
    pop = gnt == GNT_FORCE || gnt == GNT_CPU;
    // during a forced CPU slot the incoming copper write parks in hold unless hold is busy
    cop_drop = gnt == GNT_FORCE && cop_wr && hold_v;
    hold_load = cop_wr && (gnt == GNT_HOLD || (gnt == GNT_FORCE && !hold_v));
    hold_v_nxt = gnt == GNT_HOLD ? cop_wr : gnt == GNT_FORCE ? (hold_v || cop_wr) : hold_v;
    starve_nxt = (fifo_empty || pop) ? '0 :
                 ((gnt == GNT_HOLD || gnt == GNT_COP) && starve_cnt < SW'(MAX_STARVE)) ?
                 starve_cnt + 1'b1 : starve_cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_v <= 1'b0;
      hold <= '0;
      starve_cnt <= '0;
      gfx_wr <= 1'b0;
      gfx_address <= '0;
      gfx_data <= '0;
      cpu_ovf <= 1'b0;
      cop_ovr <= 1'b0;
    end else begin
      hold_v <= hold_v_nxt;
      if (hold_load) hold <= cop_in;
      starve_cnt <= starve_nxt;
      gfx_wr <= gnt != GNT_IDLE;
      if (gnt != GNT_IDLE) begin
        gfx_address <= issue.addr;
        gfx_data <= issue.data;
      end
      cpu_ovf <= (cpu_wr && fifo_full) || (cpu_ovf && !clr_flags);
      cop_ovr <= cop_drop || (cop_ovr && !clr_flags);
    end
endmodule
